// File: rtl/mem_bus_bridge_pkg.sv
// Shared types and defaults for the memory-side bus bridge.
// The optional counter feature is enabled with MEM_BUS_STATS_EN.
package membus_pkg;

    localparam int DEF_ADDR_W = 10;
    localparam int DEF_WORD_W = 12;
    localparam logic [3:0] HALT_OPCODE = 4'b0000;

    // Encoding matches the {read_write, write_commit} pair on the bus.
    typedef enum logic [1:0] {
        OP_ST_ADDR   = 2'b00,
        OP_ST_COMMIT = 2'b01,
        OP_READ      = 2'b10,
        OP_HALT      = 2'b11
    } bus_op_e;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ADDR_HELD = 2'd1,
        S_HALTED    = 2'd2
    } bridge_state_e;

    function automatic bus_op_e decode_op(input logic read_write, input logic write_commit);
        return bus_op_e'({read_write, write_commit});
    endfunction

endpackage

// File: rtl/mem_bus_bridge_if.sv
// Core bus and program-load port of the memory bridge; the core/bench drives
// the master side, the bridge implements the slave side.
interface mem_bus_bridge_if
    import membus_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int WORD_W = DEF_WORD_W
);
    logic [ADDR_W-1:0] addr_data;
    logic              read_write;
    logic              write_commit;
    logic [WORD_W-1:0] mem_result;
    logic              halted;
    logic              protocol_err;
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [WORD_W-1:0] prog_data;
    logic              prog_drop;

    modport slave (
        input  addr_data, read_write, write_commit, prog_we, prog_addr, prog_data,
        output mem_result, halted, protocol_err, prog_drop
    );

    modport master (
        output addr_data, read_write, write_commit, prog_we, prog_addr, prog_data,
        input  mem_result, halted, protocol_err, prog_drop
    );
endinterface

// File: rtl/mem_bus_bridge_mem_array.sv
// Word memory split into two half-word banks: one async read port and one
// synchronous write port with a per-half enable.
module mem_array
    import membus_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int WORD_W = DEF_WORD_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [1:0]        be,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WORD_W-1:0] rdata
);
    localparam int HALF_W = WORD_W / 2;
    localparam int DEPTH  = 2 ** ADDR_W;

    // Separate banks keep each half-word store independent of the other half.
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
        logic [HALF_W-1:0] mem_q [DEPTH];

        always_ff @(posedge clk) begin
            if (we && be[gi]) begin
                mem_q[waddr] <= wdata[gi*HALF_W +: HALF_W];
            end
        end

        assign rdata[gi*HALF_W +: HALF_W] = mem_q[raddr];
    end

endmodule

// File: rtl/mem_bus_bridge.sv
// Memory-side target of the shared addr_data bus: decode, store FSM, write
// arbitration against the preload port and sticky flags. Optional counters: MEM_BUS_STATS_EN.
module mem_bus_bridge
    import membus_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int WORD_W = DEF_WORD_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mem_bus_bridge_if.slave       bus
`ifdef MEM_BUS_STATS_EN
    ,
    output logic [15:0]           rd_count,
    output logic [15:0]           wr_count
`endif
);
    localparam int HALF_W = WORD_W / 2;

    localparam logic [1:0] IDLE      = S_IDLE;
    localparam logic [1:0] ADDR_HELD = S_ADDR_HELD;
    localparam logic [1:0] HALTED    = S_HALTED;

    bus_op_e           op;
    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] st_addr_q, st_addr_d;
    logic              protocol_err_q;
    logic              prog_drop_q;
    logic              err_set;
    logic              core_wr;

    logic              mem_we;
    logic [1:0]        mem_be;
    logic [ADDR_W-1:0] mem_waddr;
    logic [WORD_W-1:0] mem_wdata;
    logic [ADDR_W-1:0] mem_raddr;
    logic [WORD_W-1:0] mem_rdata;

    assign op = decode_op(bus.read_write, bus.write_commit);

    always_comb begin
        state_d   = state_q;
        st_addr_d = st_addr_q;
        err_set   = 1'b0;
        core_wr   = 1'b0;
        if (op == OP_HALT) begin
            state_d = HALTED;
        end else begin
            case (state_q)
                IDLE: begin
                    if (op == OP_ST_ADDR) begin
                        st_addr_d = bus.addr_data;
                        state_d   = ADDR_HELD;
                    end else if (op == OP_ST_COMMIT) begin
                        err_set = 1'b1;
                    end
                end
                ADDR_HELD: begin
                    if (op == OP_ST_ADDR) begin
                        st_addr_d = bus.addr_data;
                    end else if (op == OP_ST_COMMIT) begin
                        core_wr = 1'b1;
                        state_d = IDLE;
                    end else begin
                        err_set = 1'b1;
                        state_d = IDLE;
                    end
                end
                HALTED:  ;
                default: state_d = IDLE;
            endcase
        end
    end

    // A core commit owns the single write port; a coincident preload is lost.
    always_comb begin
        mem_we    = core_wr | bus.prog_we;
        mem_waddr = core_wr ? st_addr_q : bus.prog_addr;
        mem_wdata = core_wr ? {bus.addr_data[HALF_W-1:0], bus.addr_data[HALF_W-1:0]}
                            : bus.prog_data;
        mem_be    = core_wr ? (bus.addr_data[HALF_W] ? 2'b10 : 2'b01) : 2'b11;
        mem_raddr = (op == OP_ST_COMMIT) ? st_addr_q : bus.addr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            st_addr_q      <= '0;
            protocol_err_q <= 1'b0;
            prog_drop_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            st_addr_q      <= st_addr_d;
            protocol_err_q <= protocol_err_q | err_set;
            prog_drop_q    <= core_wr & bus.prog_we;
        end
    end

    mem_array #(
        .ADDR_W (ADDR_W),
        .WORD_W (WORD_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .be    (mem_be),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .raddr (mem_raddr),
        .rdata (mem_rdata)
    );

    assign bus.mem_result   = mem_rdata;
    assign bus.halted       = (state_q == HALTED);
    assign bus.protocol_err = protocol_err_q;
    assign bus.prog_drop    = prog_drop_q;

`ifdef MEM_BUS_STATS_EN
    logic [15:0] rd_count_q;
    logic [15:0] wr_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_count_q <= '0;
            wr_count_q <= '0;
        end else begin
            if (op == OP_READ && state_q != HALTED && rd_count_q != 16'hFFFF) begin
                rd_count_q <= rd_count_q + 16'd1;
            end
            if (core_wr && wr_count_q != 16'hFFFF) begin
                wr_count_q <= wr_count_q + 16'd1;
            end
        end
    end

    assign rd_count = rd_count_q;
    assign wr_count = wr_count_q;
`endif

endmodule
